// File: rtl/ysyx_24090018_lsu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24090018_lsu
// Purpose  : Multi-cycle load/store unit. Takes one core request over a
//            valid/ready handshake, issues one aligned strobed access on a
//            split request/response bus, formats load data and returns a
//            single response with an error flag (misaligned, illegal op,
//            bus error or timeout).
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24090018_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  // core request
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic                    req_wen_i,
  input  logic [2:0]              req_op_i,
  // core response
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o,
  output logic                    resp_timeout_o,
  // memory bus request
  output logic                    bus_req_valid_o,
  input  logic                    bus_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic                    bus_wen_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb_o,
  // memory bus response
  input  logic                    bus_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  input  logic                    bus_resp_err_i
);

  localparam int STRB = DATA_WIDTH / 8;
  localparam int OFS  = $clog2(STRB);
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Latched transaction fields
  logic [2:0]            op_q;
  logic [OFS-1:0]        ofs_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic                  bus_wen_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic [STRB-1:0]       bus_wstrb_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;
  logic                  resp_timeout_q;
  logic [CW-1:0]         count;

  // Request decode (only used to compute next-state and latched values)
  logic [OFS-1:0]        req_ofs;
  logic                  illegal;
  logic                  misaligned;
  logic                  req_bad;
  logic [7:0]            mask8;
  logic [STRB-1:0]       strb_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [ADDR_WIDTH-1:0] addr_aligned;

  logic [CW-1:0]         count_inc;
  logic                  timed_out;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_fmt;

  assign req_ofs      = req_addr_i[OFS-1:0];
  assign addr_aligned = {req_addr_i[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
  assign wdata_next   = req_wdata_i << {req_ofs, 3'b000};
  assign strb_next    = req_wen_i ? (mask8[STRB-1:0] << req_ofs) : '0;
  assign req_bad      = illegal || misaligned;

  assign count_inc = count + CW'(1);
  assign timed_out = ((state == BUS) || (state == WAIT)) && (count_inc == TIMEOUT_VAL);
  assign shifted   = bus_rdata_i >> {ofs_q, 3'b000};

  // Classify the incoming request: illegal op / size-alignment / byte mask
  always_comb begin
    illegal = (req_op_i == 3'b111) ||
              (req_wen_i && ((req_op_i == 3'b011) || req_op_i[2]));
    if ((DATA_WIDTH == 32) && ((req_op_i == 3'b011) || (req_op_i == 3'b110)))
      illegal = 1'b1;
    case (req_op_i[1:0])
      2'b01:   misaligned = req_addr_i[0];
      2'b10:   misaligned = |req_addr_i[1:0];
      2'b11:   misaligned = |req_addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
    case (req_op_i[1:0])
      2'b00:   mask8 = 8'h01;
      2'b01:   mask8 = 8'h03;
      2'b10:   mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
  end

  // Lane select plus sign/zero extension of the raw bus read data
  if (DATA_WIDTH == 64) begin : g_fmt64
    always_comb begin
      load_fmt = '0;
      case (op_q)
        3'b000:  load_fmt = {{56{shifted[7]}},  shifted[7:0]};
        3'b001:  load_fmt = {{48{shifted[15]}}, shifted[15:0]};
        3'b010:  load_fmt = {{32{shifted[31]}}, shifted[31:0]};
        3'b011:  load_fmt = shifted;
        3'b100:  load_fmt = {56'd0, shifted[7:0]};
        3'b101:  load_fmt = {48'd0, shifted[15:0]};
        3'b110:  load_fmt = {32'd0, shifted[31:0]};
        default: load_fmt = '0;
      endcase
    end
  end else begin : g_fmt32
    always_comb begin
      load_fmt = '0;
      case (op_q)
        3'b000:  load_fmt = {{24{shifted[7]}},  shifted[7:0]};
        3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
        3'b010:  load_fmt = shifted;
        3'b100:  load_fmt = {24'd0, shifted[7:0]};
        3'b101:  load_fmt = {16'd0, shifted[15:0]};
        default: load_fmt = '0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    state_next      = state;
    req_ready_o     = 1'b0;
    bus_req_valid_o = 1'b0;
    resp_valid_o    = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = req_bad ? RESP : BUS;
      end
      BUS: begin
        bus_req_valid_o = 1'b1;
        if (timed_out)            state_next = RESP;
        else if (bus_req_ready_i) state_next = WAIT;
      end
      WAIT: begin
        // a real response wins over a coincident timeout
        if (bus_resp_valid_i || timed_out) state_next = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Transaction datapath: latch request, run timeout, capture response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q           <= '0;
      ofs_q          <= '0;
      bus_addr_q     <= '0;
      bus_wen_q      <= 1'b0;
      bus_wdata_q    <= '0;
      bus_wstrb_q    <= '0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
      count          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            op_q           <= req_op_i;
            ofs_q          <= req_ofs;
            bus_addr_q     <= addr_aligned;
            bus_wen_q      <= req_wen_i;
            bus_wdata_q    <= wdata_next;
            bus_wstrb_q    <= strb_next;
            resp_rdata_q   <= '0;
            resp_err_q     <= req_bad;
            resp_timeout_q <= 1'b0;
            count          <= '0;
          end
        end
        BUS, WAIT: begin
          count <= count_inc;
          if ((state == WAIT) && bus_resp_valid_i) begin
            resp_rdata_q <= (bus_wen_q || bus_resp_err_i) ? '0 : load_fmt;
            resp_err_q   <= bus_resp_err_i;
          end else if (timed_out) begin
            resp_err_q     <= 1'b1;
            resp_timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_addr_o     = bus_addr_q;
  assign bus_wen_o      = bus_wen_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign bus_wstrb_o    = bus_wstrb_q;
  assign resp_rdata_o   = resp_rdata_q;
  assign resp_err_o     = resp_err_q;
  assign resp_timeout_o = resp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24090018_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24090018_lsu
// Purpose  : Directed self-checking bench for the load/store unit, one
//            32-bit instance (short timeout) and one 64-bit instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24090018_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        req_valid = 0, req_ready, req_wen = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0]  req_op = 0;
  logic        resp_valid, resp_ready = 0, resp_err, resp_timeout;
  logic [31:0] resp_rdata;
  logic        bus_req_valid, bus_req_ready = 0, bus_wen;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_resp_valid = 0, bus_resp_err = 0;
  logic [31:0] bus_rdata = 0;

  // 64-bit instance signals
  logic        req_valid64 = 0, req_ready64, req_wen64 = 0;
  logic [31:0] req_addr64 = 0;
  logic [63:0] req_wdata64 = 0;
  logic [2:0]  req_op64 = 0;
  logic        resp_valid64, resp_ready64 = 0, resp_err64, resp_timeout64;
  logic [63:0] resp_rdata64;
  logic        bus_req_valid64, bus_req_ready64 = 0, bus_wen64;
  logic [31:0] bus_addr64;
  logic [63:0] bus_wdata64;
  logic [7:0]  bus_wstrb64;
  logic        bus_resp_valid64 = 0, bus_resp_err64 = 0;
  logic [63:0] bus_rdata64 = 0;

  ysyx_24090018_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wen_i(req_wen), .req_op_i(req_op),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err), .resp_timeout_o(resp_timeout),
    .bus_req_valid_o(bus_req_valid), .bus_req_ready_i(bus_req_ready),
    .bus_addr_o(bus_addr), .bus_wen_o(bus_wen), .bus_wdata_o(bus_wdata),
    .bus_wstrb_o(bus_wstrb), .bus_resp_valid_i(bus_resp_valid),
    .bus_rdata_i(bus_rdata), .bus_resp_err_i(bus_resp_err)
  );

  ysyx_24090018_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(255)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid64), .req_ready_o(req_ready64), .req_addr_i(req_addr64),
    .req_wdata_i(req_wdata64), .req_wen_i(req_wen64), .req_op_i(req_op64),
    .resp_valid_o(resp_valid64), .resp_ready_i(resp_ready64), .resp_rdata_o(resp_rdata64),
    .resp_err_o(resp_err64), .resp_timeout_o(resp_timeout64),
    .bus_req_valid_o(bus_req_valid64), .bus_req_ready_i(bus_req_ready64),
    .bus_addr_o(bus_addr64), .bus_wen_o(bus_wen64), .bus_wdata_o(bus_wdata64),
    .bus_wstrb_o(bus_wstrb64), .bus_resp_valid_i(bus_resp_valid64),
    .bus_rdata_i(bus_rdata64), .bus_resp_err_i(bus_resp_err64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; returns at cycle 1 after the handshake
  task automatic req32(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] op);
    req_valid = 1; req_addr = a; req_wdata = d; req_wen = w; req_op = op;
    tick;
    req_valid = 0;
  endtask

  task automatic req64(input logic [31:0] a, input logic [63:0] d, input logic w, input logic [2:0] op);
    req_valid64 = 1; req_addr64 = a; req_wdata64 = d; req_wen64 = w; req_op64 = op;
    tick;
    req_valid64 = 0;
  endtask

  task automatic ack32;
    resp_ready = 1; tick; resp_ready = 0;
  endtask

  task automatic ack64;
    resp_ready64 = 1; tick; resp_ready64 = 0;
  endtask

  initial begin
    // ---------------- reset state
    repeat (2) tick;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_bus_valid", bus_req_valid, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_req_ready64", req_ready64, 1'b1);
    rst = 0;
    tick;

    // ---------------- lb at offset 3, zero-wait bus
    bus_req_ready = 1;
    req32(32'h8000_0003, 32'h0, 1'b0, 3'b000);
    chk("lb_bus_valid", bus_req_valid, 1'b1);
    chk("lb_bus_addr", bus_addr, 32'h8000_0000);
    chk("lb_wstrb", bus_wstrb, 4'h0);
    chk("lb_req_ready_busy", req_ready, 1'b0);
    tick;
    chk("lb_wait_bus_valid", bus_req_valid, 1'b0);
    chk("lb_wait_resp_valid", resp_valid, 1'b0);
    bus_resp_valid = 1; bus_rdata = 32'h80FF_1234;
    tick;
    bus_resp_valid = 0;
    chk("lb_resp_valid_c3", resp_valid, 1'b1);
    chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("lb_err", resp_err, 1'b0);
    ack32;
    chk("lb_idle_ready", req_ready, 1'b1);
    chk("lb_idle_resp_valid", resp_valid, 1'b0);

    // ---------------- sh at offset 2
    req32(32'h8000_0002, 32'h0000_ABCD, 1'b1, 3'b001);
    chk("sh_wdata", bus_wdata, 32'hABCD_0000);
    chk("sh_wstrb", bus_wstrb, 4'b1100);
    chk("sh_wen", bus_wen, 1'b1);
    tick;
    bus_resp_valid = 1; bus_rdata = 32'h1234_5678;
    tick;
    bus_resp_valid = 0;
    chk("sh_resp_valid", resp_valid, 1'b1);
    chk("sh_rdata", resp_rdata, 32'h0);
    chk("sh_err", resp_err, 1'b0);
    ack32;

    // ---------------- misaligned lw, then ld on a 32-bit datapath
    req32(32'h8000_0002, 32'h0, 1'b0, 3'b010);
    chk("mis_bus_valid", bus_req_valid, 1'b0);
    chk("mis_resp_valid_c1", resp_valid, 1'b1);
    chk("mis_err", resp_err, 1'b1);
    chk("mis_timeout", resp_timeout, 1'b0);
    chk("mis_rdata", resp_rdata, 32'h0);
    ack32;
    req32(32'h8000_0000, 32'h0, 1'b0, 3'b011);
    chk("ill_bus_valid", bus_req_valid, 1'b0);
    chk("ill_resp_valid", resp_valid, 1'b1);
    chk("ill_err", resp_err, 1'b1);
    ack32;

    // ---------------- bus stall 3 cycles, bus error, response backpressure
    bus_req_ready = 0;
    req32(32'h8000_0002, 32'h0, 1'b0, 3'b101);
    for (int i = 0; i < 3; i++) begin
      chk("stall_bus_valid", bus_req_valid, 1'b1);
      chk("stall_bus_addr", bus_addr, 32'h8000_0000);
      chk("stall_bus_wen", bus_wen, 1'b0);
      if (i < 2) tick;
    end
    bus_req_ready = 1;
    tick;
    chk("stall_wait_bus_valid", bus_req_valid, 1'b0);
    bus_resp_valid = 1; bus_resp_err = 1; bus_rdata = 32'hFFFF_0000;
    tick;
    bus_resp_valid = 0; bus_resp_err = 0;
    for (int i = 0; i < 3; i++) begin
      chk("berr_resp_valid", resp_valid, 1'b1);
      chk("berr_err", resp_err, 1'b1);
      chk("berr_timeout", resp_timeout, 1'b0);
      chk("berr_rdata", resp_rdata, 32'h0);
      chk("berr_req_ready", req_ready, 1'b0);
      if (i < 2) tick;
    end
    ack32;
    chk("berr_idle_ready", req_ready, 1'b1);

    // ---------------- timeout (TIMEOUT = 8), bus never responds
    req32(32'h8000_0004, 32'h0, 1'b0, 3'b010);
    repeat (7) tick;
    chk("to_before_resp_valid", resp_valid, 1'b0);
    tick;
    chk("to_resp_valid", resp_valid, 1'b1);
    chk("to_err", resp_err, 1'b1);
    chk("to_timeout", resp_timeout, 1'b1);
    chk("to_bus_valid", bus_req_valid, 1'b0);
    chk("to_rdata", resp_rdata, 32'h0);
    ack32;
    // late bus response while idle is dropped
    bus_resp_valid = 1; bus_resp_err = 1; bus_rdata = 32'hDEAD_BEEF;
    tick;
    bus_resp_valid = 0; bus_resp_err = 0;
    chk("late_resp_valid", resp_valid, 1'b0);
    chk("late_req_ready", req_ready, 1'b1);
    // next request (lhu) completes normally
    req32(32'h8000_0002, 32'h0, 1'b0, 3'b101);
    tick;
    bus_resp_valid = 1; bus_rdata = 32'h9ABC_5678;
    tick;
    bus_resp_valid = 0;
    chk("lhu_resp_valid", resp_valid, 1'b1);
    chk("lhu_rdata", resp_rdata, 32'h0000_9ABC);
    chk("lhu_err", resp_err, 1'b0);
    chk("lhu_timeout", resp_timeout, 1'b0);
    ack32;

    // ---------------- 64-bit datapath: lwu, sw
    bus_req_ready64 = 1;
    req64(32'h8000_0004, 64'h0, 1'b0, 3'b110);
    chk("lwu_bus_addr", bus_addr64, 32'h8000_0000);
    chk("lwu_bus_valid", bus_req_valid64, 1'b1);
    tick;
    bus_resp_valid64 = 1; bus_rdata64 = 64'h8765_4321_0000_0000;
    tick;
    bus_resp_valid64 = 0;
    chk("lwu_resp_valid", resp_valid64, 1'b1);
    chk("lwu_rdata", resp_rdata64, 64'h0000_0000_8765_4321);
    chk("lwu_err", resp_err64, 1'b0);
    ack64;
    req64(32'h8000_0004, 64'h1122_3344, 1'b1, 3'b010);
    chk("sw64_wdata", bus_wdata64, 64'h1122_3344_0000_0000);
    chk("sw64_wstrb", bus_wstrb64, 8'hF0);
    tick;
    bus_resp_valid64 = 1; bus_rdata64 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    bus_resp_valid64 = 0;
    chk("sw64_rdata", resp_rdata64, 64'h0);
    chk("sw64_err", resp_err64, 1'b0);
    ack64;

    // ---------------- reset while waiting for the bus response
    req64(32'h8000_0008, 64'h0, 1'b0, 3'b011);
    tick;
    rst = 1;
    #1;
    chk("rstw_bus_valid", bus_req_valid64, 1'b0);
    chk("rstw_resp_valid", resp_valid64, 1'b0);
    chk("rstw_bus_addr", bus_addr64, 32'h0);
    bus_resp_valid64 = 1; bus_rdata64 = 64'hAAAA_BBBB_CCCC_DDDD;
    tick;
    rst = 0;
    tick;
    bus_resp_valid64 = 0;
    chk("rstw_after_resp_valid", resp_valid64, 1'b0);
    chk("rstw_after_req_ready", req_ready64, 1'b1);
    // full 64-bit load passes through untouched
    req64(32'h8000_0008, 64'h0, 1'b0, 3'b011);
    tick;
    bus_resp_valid64 = 1; bus_rdata64 = 64'hDEAD_BEEF_0123_4567;
    tick;
    bus_resp_valid64 = 0;
    chk("ld_resp_valid", resp_valid64, 1'b1);
    chk("ld_rdata", resp_rdata64, 64'hDEAD_BEEF_0123_4567);
    ack64;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
